// File: rtl/rom_reader_if.sv
// Burst ROM reader bus: start/base/len command, ROM read port and output stream.
// ROM_READER_STRIDE_EN adds the stride command field.
interface rom_reader_if #(
   parameter int DW = 16,
   parameter int AW = 10
);
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
`ifdef ROM_READER_STRIDE_EN
   logic [AW-1:0] stride;
`endif
   logic          busy;
   logic          done;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport slave (
`ifdef ROM_READER_STRIDE_EN
      input  stride,
`endif
      input  start, base, len, mem_dout, out_ready,
      output busy, done, mem_en, mem_addr, out_valid, out_data, out_last
   );

   modport master (
`ifdef ROM_READER_STRIDE_EN
      output stride,
`endif
      output start, base, len, mem_dout, out_ready,
      input  busy, done, mem_en, mem_addr, out_valid, out_data, out_last
   );
endinterface

// File: rtl/rom_reader.sv
// Streams len ROM words from base through a 2-entry buffer with bypass of the in-flight read.
// Optional ROM_READER_STRIDE_EN: address advances by a sampled stride instead of 1.
module rom_reader #(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input logic         clk,
   input logic         nreset,
   rom_reader_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_len;
   logic [AW:0]   r_issued;
   logic [AW:0]   r_sent;
   logic [DW-1:0] r_buf [0:1];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;
   logic          r_inflight;
`ifdef ROM_READER_STRIDE_EN
   logic [AW-1:0] r_stride;
`endif

   logic [AW-1:0] w_step;
   logic          w_valid;
   logic          w_pop;
   logic          w_last;
   logic          w_mem_en;
   logic          w_push;
   logic          w_buf_pop;
   logic [2:0]    w_occ;

`ifdef ROM_READER_STRIDE_EN
   assign w_step = r_stride;
`else
   assign w_step = {{(AW-1){1'b0}}, 1'b1};
`endif

   // The in-flight word is visible on mem_dout, so it counts as a buffered beat.
   assign w_valid   = (r_count != 2'd0) || r_inflight;
   assign w_pop     = w_valid && bus.out_ready;
   assign w_last    = ((r_sent + {{AW{1'b0}}, 1'b1}) == r_len);
   assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_buf_pop = w_pop && (r_count != 2'd0);
   assign w_push    = r_inflight && !(w_pop && (r_count == 2'd0));

   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE);
   assign bus.mem_en    = w_mem_en;
   assign bus.mem_addr  = w_mem_en ? r_addr : {AW{1'b0}};
   assign bus.out_valid = w_valid;
   assign bus.out_last  = w_valid && w_last;
   assign bus.out_data  = !w_valid ? {DW{1'b0}} :
                          ((r_count != 2'd0) ? r_buf[r_rd_ptr] : bus.mem_dout);

   // State register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and read-enable decode.
   always_comb begin
      w_state_nxt = r_state;
      w_mem_en    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = (bus.len == {(AW+1){1'b0}}) ? DONE : RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            w_mem_en = (r_issued < r_len) && (w_occ < 3'd2);
            if (w_pop && w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Burst counters, address generator and output buffer.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_addr     <= {AW{1'b0}};
         r_len      <= {(AW+1){1'b0}};
         r_issued   <= {(AW+1){1'b0}};
         r_sent     <= {(AW+1){1'b0}};
         r_buf[0]   <= {DW{1'b0}};
         r_buf[1]   <= {DW{1'b0}};
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
`ifdef ROM_READER_STRIDE_EN
         r_stride   <= {AW{1'b0}};
`endif
      end else begin
         if ((r_state == IDLE) && bus.start) begin
            r_addr   <= bus.base;
            r_len    <= bus.len;
            r_issued <= {(AW+1){1'b0}};
            r_sent   <= {(AW+1){1'b0}};
`ifdef ROM_READER_STRIDE_EN
            r_stride <= bus.stride;
`endif
         end else begin
            if (w_mem_en) begin
               r_addr   <= r_addr + w_step;
               r_issued <= r_issued + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
               r_sent <= r_sent + {{AW{1'b0}}, 1'b1};
            end
         end
         r_inflight <= w_mem_en;
         if (w_push) begin
            r_buf[r_wr_ptr] <= bus.mem_dout;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_buf_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_buf_pop};
      end
   end
endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: ROM model mem[i]=i, expected reads and beats queued at start.
module tb_rom_reader;
   localparam int DW = 16;
   localparam int AW = 10;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   rom_reader_if #(.DW(DW), .AW(AW)) bus ();
   rom_reader #(.DW(DW), .AW(AW)) dut (.clk(clk), .nreset(nreset), .bus(bus.slave));

   beat_t         dq[$];
   logic [AW-1:0] aq[$];
   int            n_cmp   = 0;
   int            n_err   = 0;
   int            n_out   = 0;
   int            n_beats = 0;
   logic          exp_busy = 1'b0;
   logic          exp_done = 1'b0;
   logic          nxt_busy;
   logic          nxt_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ROM with one cycle of read latency.
   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_dout <= {{(DW-AW){1'b0}}, bus.mem_addr};
   end

   // Monitor: compare reads, beats, busy and done against the scoreboard.
   always @(negedge clk) begin
      if (!nreset) begin
         dq.delete();
         aq.delete();
         exp_busy = 1'b0;
         exp_done = 1'b0;
         n_out    = 0;
      end else begin
         check("busy", bus.busy, exp_busy);
         check("done", bus.done, exp_done);
         nxt_done = 1'b0;
         nxt_busy = exp_busy;
         if (bus.start && !exp_busy) begin
            nxt_busy = 1'b1;
            if (bus.len == 0) nxt_done = 1'b1;
         end else if (exp_done) begin
            nxt_busy = 1'b0;
         end
         if (bus.mem_en) begin
            n_out++;
            if (aq.size() == 0) check("rd_extra", 1, 0);
            else check("rd_addr", bus.mem_addr, aq.pop_front());
         end else begin
            check("addr_idle", bus.mem_addr, 0);
         end
         if (bus.out_valid) begin
            if (dq.size() == 0) begin
               check("beat_extra", 1, 0);
            end else begin
               check("data", bus.out_data, dq[0].data);
               check("last", bus.out_last, dq[0].last);
               if (bus.out_ready) begin
                  n_out--;
                  n_beats++;
                  if (dq[0].last) nxt_done = 1'b1;
                  void'(dq.pop_front());
               end
            end
         end
         check("occupancy", (n_out <= 2), 1);
         exp_busy = nxt_busy;
         exp_done = nxt_done;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_mem_en"}, bus.mem_en, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_data"}, bus.out_data, 0);
      check({tag, "_out_last"}, bus.out_last, 0);
   endtask

   task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l, input logic [AW-1:0] st);
      logic [AW-1:0] a;
      beat_t         e;
      a         = b;
      bus.start = 1'b1;
      bus.base  = b;
      bus.len   = l;
`ifdef ROM_READER_STRIDE_EN
      bus.stride = st;
`endif
      for (int i = 0; i < int'(l); i++) begin
         aq.push_back(a);
         e.data = {{(DW-AW){1'b0}}, a};
         e.last = (i == int'(l) - 1);
         dq.push_back(e);
         a = a + st;
      end
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
   task automatic wait_done(input int mode, input int exp_cyc, input bit inject);
      int cyc  = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         bus.start = inject && (cyc == 3);
         if (inject && cyc == 3) begin
            bus.base = 10'd500;
            bus.len  = 11'd3;
         end
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         if (bus.done) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      if (exp_cyc != 0) check("latency", cyc, exp_cyc);
      check("drained", dq.size() + aq.size(), 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
   endtask

   task automatic burst(input logic [AW-1:0] b, input logic [AW:0] l, input logic [AW-1:0] st,
                        input int mode, input int exp_cyc, input bit inject);
      start_burst(b, l, st);
      wait_done(mode, exp_cyc, inject);
   endtask

   initial begin
      int b0;
      int guard;
      nreset        = 1'b1;
      bus.start     = 1'b0;
      bus.base      = 10'd0;
      bus.len       = 11'd0;
      bus.out_ready = 1'b1;
`ifdef ROM_READER_STRIDE_EN
      bus.stride    = 10'd1;
`endif
      #2;
      nreset = 1'b0;
      #2;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      nreset = 1'b1;

      burst(10'd5, 11'd4, 10'd1, 0, 6, 1'b0);
      burst(10'd1022, 11'd4, 10'd1, 0, 6, 1'b0);
      burst(10'd0, 11'd8, 10'd1, 1, 0, 1'b1);
      burst(10'd0, 11'd0, 10'd1, 0, 1, 1'b0);

      start_burst(10'd100, 11'd10, 10'd1);
      b0    = n_beats;
      guard = 0;
      do begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         guard++;
      end while (n_beats < b0 + 2 && guard < 100);
      check("third_beat_reached", (n_beats >= b0 + 2), 1);
      nreset = 1'b0;
      #1;
      check_zero("midreset");
      @(posedge clk);
      #1;
      nreset = 1'b1;
      burst(10'd0, 11'd2, 10'd1, 0, 4, 1'b0);

      burst(10'd7, 11'd1024, 10'd1, 0, 1026, 1'b0);
      burst(10'd1000, 11'd20, 10'd1, 2, 0, 1'b0);
`ifdef ROM_READER_STRIDE_EN
      burst(10'd0, 11'd5, 10'd256, 0, 7, 1'b0);
`endif
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
